// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch redirect controller: FSM states, PC source tags
// and the default PC width.
package fetch_ctrl_pkg;
  localparam int WIDTH_DEF = 31;
  localparam int PC_W      = WIDTH_DEF + 1;

  typedef enum logic [1:0] {RUN, HOLD, RECOVER} fetch_state_t;
  typedef enum logic [2:0] {SRC_COMMIT, SRC_PENDING, SRC_DECODE, SRC_BTB, SRC_SEQ} pc_src_t;

  function automatic logic is_decode_src(pc_src_t s);
    return (s == SRC_PENDING) || (s == SRC_DECODE);
  endfunction
endpackage

// File: rtl/pc_source_mux.sv
// Fixed-priority next-PC selector: commit > pending > decode > BTB > PC+1.
module pc_source_mux
  import fetch_ctrl_pkg::*;
#(
  parameter int PC_W = fetch_ctrl_pkg::PC_W
) (
  input  logic            commit_vld,
  input  logic            pend_vld,
  input  logic            dec_vld,
  input  logic            btb_vld,
  input  logic [PC_W-1:0] commit_pc,
  input  logic [PC_W-1:0] pend_pc,
  input  logic [PC_W-1:0] dec_pc,
  input  logic [PC_W-1:0] btb_pc,
  input  logic [PC_W-1:0] cur_pc,
  output pc_src_t         src,
  output logic [PC_W-1:0] next_pc
);
  always_comb begin
    src     = SRC_SEQ;
    next_pc = cur_pc + PC_W'(1);
    if (commit_vld) begin
      src     = SRC_COMMIT;
      next_pc = commit_pc;
    end else if (pend_vld) begin
      src     = SRC_PENDING;
      next_pc = pend_pc;
    end else if (dec_vld) begin
      src     = SRC_DECODE;
      next_pc = dec_pc;
    end else if (btb_vld) begin
      src     = SRC_BTB;
      next_pc = btb_pc;
    end
  end
endmodule

// File: rtl/fetch_redirect_controller.sv
// Front-end fetch PC owner: redirect arbitration, freeze hold with pending
// decode redirect, post-commit recovery window. REDIRECT_STATS_EN adds counters.
module fetch_redirect_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int             WIDTH          = 31,
  parameter logic [WIDTH:0] RESET_PC       = '0,
  parameter int             RECOVER_CYCLES = 2,
  parameter int             STAT_W         = 16
) (
  input  logic              clk,
  input  logic              globalReset,
  input  logic              freeze,
  input  logic              commitRedirect,
  input  logic [WIDTH:0]    targetAddress,
  input  logic              earlyMisdirect,
  input  logic [WIDTH:0]    validAddress,
  input  logic              predictorHit,
  input  logic [WIDTH:0]    predictedPC,
  output logic [WIDTH:0]    fetchPC,
  output logic              fetchValid,
  output logic              redirect,
  output logic              flushFrontend,
  output logic              pendingRedirect,
  output logic [STAT_W-1:0] commitRedirectCount,
  output logic [STAT_W-1:0] decodeRedirectCount,
  output logic [STAT_W-1:0] freezeCycleCount
);
  localparam int PCW   = WIDTH + 1;
  localparam int CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  fetch_state_t   state, state_nxt;
  logic [CNT_W-1:0] rcnt, rcnt_nxt;
  logic           pend_vld_nxt;
  logic [PCW-1:0] pend_pc, pend_pc_nxt, pc_nxt, mux_pc;
  logic           redirect_nxt, sel_en;
  pc_src_t        src;

  // Only commit may move the PC while frozen or recovering.
  assign sel_en = (state != RECOVER) && !freeze;

  pc_source_mux #(.PC_W(PCW)) u_mux (
    .commit_vld (commitRedirect),
    .pend_vld   (sel_en && pendingRedirect),
    .dec_vld    (sel_en && earlyMisdirect),
    .btb_vld    (sel_en && predictorHit),
    .commit_pc  (targetAddress),
    .pend_pc    (pend_pc),
    .dec_pc     (validAddress),
    .btb_pc     (predictedPC),
    .cur_pc     (fetchPC),
    .src        (src),
    .next_pc    (mux_pc)
  );

  always_comb begin
    state_nxt    = state;
    rcnt_nxt     = rcnt;
    pend_vld_nxt = pendingRedirect;
    pend_pc_nxt  = pend_pc;
    pc_nxt       = fetchPC;
    redirect_nxt = 1'b0;
    if (commitRedirect) begin
      pc_nxt       = mux_pc;
      pend_vld_nxt = 1'b0;
      if (RECOVER_CYCLES > 0) begin
        state_nxt = RECOVER;
        rcnt_nxt  = CNT_W'(RECOVER_CYCLES - 1);
      end else begin
        state_nxt = RUN;
      end
    end else begin
      case (state)
        RECOVER: begin
          if (rcnt == '0) state_nxt = RUN;
          else            rcnt_nxt  = rcnt - CNT_W'(1);
        end
        default: begin
          if (freeze) begin
            state_nxt = HOLD;
            if (earlyMisdirect) begin
              pend_vld_nxt = 1'b1;
              pend_pc_nxt  = validAddress;
            end
          end else begin
            state_nxt    = RUN;
            pc_nxt       = mux_pc;
            redirect_nxt = (src == SRC_BTB);
            if (src == SRC_PENDING) pend_vld_nxt = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      state           <= RUN;
      rcnt            <= '0;
      fetchPC         <= RESET_PC;
      fetchValid      <= 1'b1;
      redirect        <= 1'b0;
      flushFrontend   <= 1'b0;
      pendingRedirect <= 1'b0;
      pend_pc         <= '0;
    end else begin
      state           <= state_nxt;
      rcnt            <= rcnt_nxt;
      fetchPC         <= pc_nxt;
      fetchValid      <= (state_nxt != RECOVER);
      redirect        <= redirect_nxt;
      flushFrontend   <= commitRedirect;
      pendingRedirect <= pend_vld_nxt;
      pend_pc         <= pend_pc_nxt;
    end
  end

`ifdef REDIRECT_STATS_EN
  logic [STAT_W-1:0] ccnt, dcnt, fcnt;
  logic              dec_applied;

  assign dec_applied = !commitRedirect && sel_en && is_decode_src(src);

  // Saturating event counters.
  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      ccnt <= '0;
      dcnt <= '0;
      fcnt <= '0;
    end else begin
      if (commitRedirect && (ccnt != '1)) ccnt <= ccnt + STAT_W'(1);
      if (dec_applied && (dcnt != '1))    dcnt <= dcnt + STAT_W'(1);
      if ((state == HOLD) && (fcnt != '1)) fcnt <= fcnt + STAT_W'(1);
    end
  end

  assign commitRedirectCount = ccnt;
  assign decodeRedirectCount = dcnt;
  assign freezeCycleCount    = fcnt;
`else
  assign commitRedirectCount = '0;
  assign decodeRedirectCount = '0;
  assign freezeCycleCount    = '0;
`endif
endmodule

// File: doc/fetch_redirect_controller.md
Name: fetch_redirect_controller

Overview:
Sequencing controller for the front-end PC selection path. Each cycle it picks one of four fetch-address sources (commit redirect, decode early-misdirect, BTB prediction, sequential PC+1) and owns the registered fetch PC. It also applies pipeline freeze, holds decode redirects that arrive during a freeze, and runs a post-mispredict recovery window. It sits between commit/decode/BTB and the instruction-memory address port.

Parameters:
WIDTH, 31, MSB index of PC; PC is WIDTH+1 bits, word-addressed (sequential step = 1).
RESET_PC, 0, fetch address after reset.
RECOVER_CYCLES, 2, fetch-invalid cycles after a commit redirect; 0 = no recovery window.
STAT_W, 16, width of optional statistic counters.

Ports:
clk  in  1  core clock; all state updates on rising edge.
globalReset  in  1  asynchronous, active-high reset.
freeze  in  1  RS/ROB full; hold fetch PC.
commitRedirect  in  1  commit-stage mispredict/misdirect.
targetAddress  in  WIDTH+1  correct PC from commit.
earlyMisdirect  in  1  decode found JAL or a wrong BTB redirect.
validAddress  in  WIDTH+1  corrected PC from decode.
predictorHit  in  1  BTB hit, predicted taken, for current fetchPC.
predictedPC  in  WIDTH+1  BTB target.
fetchPC  out  WIDTH+1  registered current fetch address.
fetchValid  out  1  fetchPC is a real fetch this cycle.
redirect  out  1  registered; 1 when fetchPC came from predictedPC.
flushFrontend  out  1  registered one-cycle pulse after a commit redirect.
pendingRedirect  out  1  decode redirect is held during freeze.
commitRedirectCount  out  STAT_W  optional statistic.
decodeRedirectCount  out  STAT_W  optional statistic.
freezeCycleCount  out  STAT_W  optional statistic.

Behaviour:
- Reset (async, immediate): fetchPC=RESET_PC; fetchValid=1; state=RUN; redirect, flushFrontend and pendingRedirect = 0; recovery counter=0; pending register cleared; statistic counters=0.
- States are RUN, HOLD and RECOVER. Every next-state and next-PC decision takes effect at the next edge (1-cycle latency).
- commitRedirect has absolute priority in every state, including during freeze:
  - fetchPC <= targetAddress; flushFrontend <= 1 for one cycle.
  - The pending register is cleared.
  - If RECOVER_CYCLES>0: state <= RECOVER, counter <= RECOVER_CYCLES-1. Otherwise state <= RUN.
- RUN, freeze=0, no commitRedirect. Priority order:
  - pending register if valid (then it is consumed);
  - else earlyMisdirect -> validAddress;
  - else predictorHit -> predictedPC, with redirect <= 1;
  - else fetchPC+1.
  - In all other cases redirect <= 0. fetchValid=1.
- RUN, freeze=1: fetchPC holds; state <= HOLD. An earlyMisdirect in this cycle is latched into the pending register.
- HOLD:
  - fetchPC holds; fetchValid=1 (same address re-presented); predictorHit is ignored.
  - earlyMisdirect latches validAddress into the pending register. A newer value overwrites an older one; pendingRedirect=1.
  - When freeze drops: state <= RUN, and the same-cycle RUN selection applies, so the pending/decode target beats the BTB.
- RECOVER:
  - fetchValid=0; fetchPC holds the target.
  - earlyMisdirect, predictorHit and freeze are ignored.
  - Counter decrements each cycle. At 0: state <= RUN, and fetchValid=1 on the following cycle at the same fetchPC.
  - A new commitRedirect restarts the window with the new target.
- Arithmetic: fetchPC+1 wraps modulo 2^(WIDTH+1) with no flag.
- Simultaneous events:
  - commitRedirect together with freeze or earlyMisdirect: commit wins and decode is dropped.
  - freeze together with predictorHit: the prediction is dropped.

Optional Feature:
REDIRECT_STATS_EN:
- When defined, three saturating STAT_W counters increment:
  - commitRedirectCount on each accepted commitRedirect;
  - decodeRedirectCount on each decode redirect actually applied to fetchPC;
  - freezeCycleCount on each cycle in HOLD.
- Each counter holds at all-ones.
- When not defined, the ports remain and are tied to 0, and no counter flops are built.

Decomposition:
- Package fetch_ctrl_pkg holds:
  - the fetch_state_t enum {RUN, HOLD, RECOVER};
  - the pc_src_t enum {SRC_COMMIT, SRC_PENDING, SRC_DECODE, SRC_BTB, SRC_SEQ};
  - a PC-width localparam derived from WIDTH.
- One combinational sub-module, pc_source_mux, takes the source-valid bits and addresses and returns the pc_src_t and the next PC. The FSM, pending register and counters stay in the top module.

Test Plan:
- Reset, then idle for 3 cycles -> fetchPC 0,1,2,3; fetchValid=1; redirect=0.
- fetchPC=10, earlyMisdirect=1 with validAddress=20, and predictorHit=1 with predictedPC=4 -> next fetchPC=20, redirect=0; then 21.
- predictorHit=1 with predictedPC=30 -> fetchPC=30, redirect=1. Then commitRedirect with targetAddress=50 and RECOVER_CYCLES=2 -> flushFrontend pulse, fetchPC=50, fetchValid=0 for 2 cycles, then 50 valid, then 51.
- freeze=1 for 3 cycles at fetchPC=51 with earlyMisdirect (validAddress=80) in cycle 2 and predictorHit (predictedPC=70) -> fetchPC stays 51, pendingRedirect=1. On release, fetchPC=80, pending cleared.
- freeze=1 with a pending redirect at 80, then commitRedirect with targetAddress=100 -> fetchPC=100, pending dropped, state RECOVER.
- fetchPC=all-ones, idle -> wraps to 0. With REDIRECT_STATS_EN, after 2 commit redirects, 1 applied decode redirect and 3 freeze cycles -> counts read 2, 1, 3.
